// File: rtl/ooo_types_pkg.sv
// ooo_types_pkg: shared types and constants for the out-of-order retire stage.
//   SUPERSCALAR             entries inspected / retired per cycle
//   SUPERSCALAR_BITS        log2(SUPERSCALAR)
//   PHYS_BITS               physical register index width
//   RECOVER_CYCLES_DEFAULT  default hold time in RECOVER after a flush
//   rob_entry_t             one reorder-buffer entry as seen at the queue head
//   commit_state_t          retire FSM states
//   count_t                 0..SUPERSCALAR retire count
package ooo_types_pkg;

   localparam int SUPERSCALAR            = 4;
   localparam int SUPERSCALAR_BITS       = 2;
   localparam int PHYS_BITS              = 6;
   localparam int RECOVER_CYCLES_DEFAULT = 2;

   typedef struct packed {
      logic                 valid;
      logic                 done;
      logic                 mispredict;
      logic [4:0]           rd;
      logic [PHYS_BITS-1:0] pd;
      logic [PHYS_BITS-1:0] pd_old;
      logic [31:0]          target_pc;
   } rob_entry_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } commit_state_t;

   // One extra bit so that a full SUPERSCALAR-wide retire is representable.
   typedef logic [SUPERSCALAR_BITS:0] count_t;

endpackage

// File: rtl/commit_prefix_scan.sv
// commit_prefix_scan: combinational in-order prefix scan over the head entries.
//   valid_i, done_i, mispredict_i  per-lane flags, lane 0 = oldest
//   k_o                            length of the retirable prefix
//   mispredict_hit_o               the prefix ends on a mispredicted entry
//   mispredict_lane_o              lane of that entry (meaningful with hit)
module commit_prefix_scan
   import ooo_types_pkg::*;
(
   input  logic [SUPERSCALAR-1:0]      valid_i,
   input  logic [SUPERSCALAR-1:0]      done_i,
   input  logic [SUPERSCALAR-1:0]      mispredict_i,
   output count_t                      k_o,
   output logic                        mispredict_hit_o,
   output logic [SUPERSCALAR_BITS-1:0] mispredict_lane_o
);

   logic stop;

   // A mispredicted entry retires itself but nothing younger; a not-ready
   // entry ends the run without retiring.
   always_comb begin
      k_o               = '0;
      mispredict_hit_o  = 1'b0;
      mispredict_lane_o = '0;
      stop              = 1'b0;
      for (int i = 0; i < SUPERSCALAR; i++) begin
         if (!stop) begin
            if (valid_i[i] && done_i[i]) begin
               k_o = k_o + count_t'(1);
               if (mispredict_i[i]) begin
                  mispredict_hit_o  = 1'b1;
                  mispredict_lane_o = SUPERSCALAR_BITS'(i);
                  stop              = 1'b1;
               end
            end else begin
               stop = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rob_commit.sv
// rob_commit: retire stage behind the reorder-buffer circular queue.
// Retires the valid&done in-order prefix of the head entries, pops the queue,
// publishes retired mappings and freed physical regs, and raises a one-cycle
// redirect flush when a mispredicted entry retires.
//   clk, rst       clock; asynchronous active-high reset
//   head_entry     oldest queue entries, [0] = oldest
//   commit_stall   downstream backpressure, retire nothing
//   pop, amount    combinational dequeue request and count
//   ret_valid      lanes retired on the previous edge
//   ret_rd/ret_pd  architectural dest and new mapping per lane
//   free_pd        previous mapping to return to the free list
//   flush          one-cycle redirect pulse, redirect_pc valid with it
// Optional: COMMIT_TRACE_EN adds commit_count and per-lane ret_order.
//
// state   | meaning
// RUN     | normal retirement of the head prefix
// RECOVER | flush in progress; head ignored for RECOVER_CYCLES cycles
module rob_commit
   import ooo_types_pkg::*;
#(
   parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEFAULT
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  rob_entry_t                           head_entry [SUPERSCALAR],
   input  logic                                 commit_stall,
   output logic                                 pop,
   output count_t                               amount,
   output logic [SUPERSCALAR-1:0]               ret_valid,
   output logic [SUPERSCALAR-1:0][4:0]          ret_rd,
   output logic [SUPERSCALAR-1:0][PHYS_BITS-1:0] ret_pd,
   output logic [SUPERSCALAR-1:0][PHYS_BITS-1:0] free_pd,
   output logic                                 flush,
   output logic [31:0]                          redirect_pc
`ifdef COMMIT_TRACE_EN
   ,
   output logic [63:0]                          commit_count,
   output logic [SUPERSCALAR-1:0][63:0]         ret_order
`endif
);

   localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);

   commit_state_t                 state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [SUPERSCALAR-1:0]        valid_v, done_v, mp_v;
   count_t                        k_raw, k_eff;
   logic                          mp_hit, take_mp;
   logic [SUPERSCALAR_BITS-1:0]   mp_lane;
   logic [SUPERSCALAR-1:0]        retire_mask;

   always_comb begin
      for (int i = 0; i < SUPERSCALAR; i++) begin
         valid_v[i] = head_entry[i].valid;
         done_v[i]  = head_entry[i].done;
         mp_v[i]    = head_entry[i].mispredict;
      end
   end

   commit_prefix_scan u_scan (
      .valid_i           (valid_v),
      .done_i            (done_v),
      .mispredict_i      (mp_v),
      .k_o               (k_raw),
      .mispredict_hit_o  (mp_hit),
      .mispredict_lane_o (mp_lane)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_eff   = '0;
      take_mp = 1'b0;
      unique case (state_q)
         RUN: begin
            if (!commit_stall) begin
               k_eff   = k_raw;
               take_mp = mp_hit;
            end
            if (take_mp) begin
               state_d = RECOVER;
               cnt_d   = CNT_W'(RECOVER_CYCLES);
            end
         end
         RECOVER: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      for (int i = 0; i < SUPERSCALAR; i++) begin
         retire_mask[i] = (k_eff > count_t'(i));
      end
   end

   // The queue must not see a dequeue while reset is held, even combinationally.
   assign pop    = !rst && (k_eff != '0);
   assign amount = rst ? '0 : k_eff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         ret_valid   <= '0;
         ret_rd      <= '0;
         ret_pd      <= '0;
         free_pd     <= '0;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ret_valid <= retire_mask;
         flush     <= take_mp;
         if (take_mp) redirect_pc <= head_entry[mp_lane].target_pc;
         for (int i = 0; i < SUPERSCALAR; i++) begin
            if (retire_mask[i]) begin
               ret_rd[i]  <= head_entry[i].rd;
               ret_pd[i]  <= head_entry[i].pd;
               free_pd[i] <= head_entry[i].pd_old;
            end
         end
      end
   end

`ifdef COMMIT_TRACE_EN
   // ret_order is registered alongside ret_valid so each lane carries the
   // sequence number it had when it retired.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_count <= '0;
         ret_order    <= '0;
      end else if (k_eff != '0) begin
         commit_count <= commit_count + 64'(k_eff);
         for (int i = 0; i < SUPERSCALAR; i++) begin
            if (retire_mask[i]) ret_order[i] <= commit_count + 64'(i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
   import ooo_types_pkg::*;

   logic                                  clk;
   logic                                  rst;
   rob_entry_t                            he [SUPERSCALAR];
   logic                                  stall;
   logic                                  pop;
   count_t                                amount;
   logic [SUPERSCALAR-1:0]                ret_valid;
   logic [SUPERSCALAR-1:0][4:0]           ret_rd;
   logic [SUPERSCALAR-1:0][PHYS_BITS-1:0] ret_pd;
   logic [SUPERSCALAR-1:0][PHYS_BITS-1:0] free_pd;
   logic                                  flush;
   logic [31:0]                           redirect_pc;
`ifdef COMMIT_TRACE_EN
   logic [63:0]                           commit_count;
   logic [SUPERSCALAR-1:0][63:0]          ret_order;
`endif

   rob_commit dut (
      .clk          (clk),
      .rst          (rst),
      .head_entry   (he),
      .commit_stall (stall),
      .pop          (pop),
      .amount       (amount),
      .ret_valid    (ret_valid),
      .ret_rd       (ret_rd),
      .ret_pd       (ret_pd),
      .free_pd      (free_pd),
      .flush        (flush),
      .redirect_pc  (redirect_pc)
`ifdef COMMIT_TRACE_EN
      ,
      .commit_count (commit_count),
      .ret_order    (ret_order)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     rec_left = 0;       // model: cycles still to spend ignoring the head
   longint exp_count = 0;      // model: total entries retired since reset

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_entries(input logic [3:0] v, input logic [3:0] d, input logic [3:0] m);
      for (int i = 0; i < SUPERSCALAR; i++) begin
         he[i].valid      = v[i];
         he[i].done       = d[i];
         he[i].mispredict = m[i];
         he[i].rd         = 5'($urandom);
         he[i].pd         = PHYS_BITS'($urandom);
         he[i].pd_old     = PHYS_BITS'($urandom);
         he[i].target_pc  = $urandom;
      end
   endtask

   // Reference: in-order retirement, stop after a retired mispredict,
   // nothing while stalled or while the flush is settling.
   function automatic int model_k();
      int n = 0;
      if (rec_left > 0 || stall) return 0;
      for (int i = 0; i < SUPERSCALAR; i++) begin
         if (!(he[i].valid && he[i].done)) break;
         n++;
         if (he[i].mispredict) break;
      end
      return n;
   endfunction

   // Called at posedge+1 with inputs stable; checks one full cycle.
   task automatic step(input int exp_k);
      rob_entry_t snap [SUPERSCALAR];
      logic       exp_fl;
      logic [3:0] m;
      @(negedge clk);
      check("pop", 64'(pop), 64'(exp_k != 0));
      check("amount", 64'(amount), 64'(exp_k));
      snap   = he;
      exp_fl = (exp_k > 0) && snap[exp_k-1].mispredict;
      m      = 4'((1 << exp_k) - 1);
      @(posedge clk);
      #1;
      check("ret_valid", 64'(ret_valid), 64'(m));
      for (int i = 0; i < exp_k; i++) begin
         check("ret_rd", 64'(ret_rd[i]), 64'(snap[i].rd));
         check("ret_pd", 64'(ret_pd[i]), 64'(snap[i].pd));
         check("free_pd", 64'(free_pd[i]), 64'(snap[i].pd_old));
      end
      check("flush", 64'(flush), 64'(exp_fl));
      if (exp_fl) check("redirect_pc", 64'(redirect_pc), 64'(snap[exp_k-1].target_pc));
`ifdef COMMIT_TRACE_EN
      if (exp_k > 0) check("ret_order0", ret_order[0], 64'(exp_count));
      exp_count += exp_k;
      check("commit_count", commit_count, 64'(exp_count));
`endif
      if (rec_left > 0) rec_left--;
      if (exp_fl) rec_left = RECOVER_CYCLES_DEFAULT;
   endtask

   typedef struct {
      logic [3:0] v;
      logic [3:0] d;
      logic [3:0] m;
      logic       st;
      logic       rd0_zero;
      int         exp_amt;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 4};  // all retire
      vecs[1]  = '{4'hF, 4'hB, 4'h0, 1'b0, 1'b0, 2};  // lane 2 not done
      vecs[2]  = '{4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 0};  // stalled
      vecs[3]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0};  // empty queue
      vecs[4]  = '{4'hE, 4'hF, 4'h0, 1'b0, 1'b0, 0};  // oldest invalid
      vecs[5]  = '{4'hF, 4'hF, 4'h2, 1'b0, 1'b0, 2};  // mispredict lane 1
      vecs[6]  = '{4'hF, 4'hF, 4'h8, 1'b0, 1'b0, 4};  // mispredict lane 3
      vecs[7]  = '{4'hF, 4'hF, 4'h1, 1'b0, 1'b0, 1};  // mispredict lane 0
      vecs[8]  = '{4'hF, 4'hE, 4'h0, 1'b0, 1'b0, 0};  // oldest not done
      vecs[9]  = '{4'h7, 4'hF, 4'h0, 1'b0, 1'b0, 3};  // three valid
      vecs[10] = '{4'hF, 4'hB, 4'h4, 1'b0, 1'b0, 2};  // mispredict on undone lane
      vecs[11] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 4};  // rd==0 still retires

      // Reset: comb outputs gated even with retirable entries presented.
      rst   = 1'b1;
      stall = 1'b0;
      set_entries(4'hF, 4'hF, 4'h0);
      #3;
      check("rst_pop", 64'(pop), 64'd0);
      check("rst_amount", 64'(amount), 64'd0);
      check("rst_ret_valid", 64'(ret_valid), 64'd0);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
      check("rst_ret_rd", 64'(ret_rd), 64'd0);
`ifdef COMMIT_TRACE_EN
      check("rst_commit_count", commit_count, 64'd0);
`endif
      set_entries(4'h0, 4'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table vectors; after a flush, present ready entries that must be ignored.
      for (int t = 0; t < 12; t++) begin
         set_entries(vecs[t].v, vecs[t].d, vecs[t].m);
         if (vecs[t].rd0_zero) he[0].rd = 5'd0;
         stall = vecs[t].st;
         step(vecs[t].exp_amt);
         stall = 1'b0;
         while (rec_left > 0) begin
            set_entries(4'hF, 4'hF, 4'h0);
            step(0);
         end
      end

      // Lane 1 mispredict to a known PC, two recover cycles, then resume.
      set_entries(4'hF, 4'hF, 4'h2);
      he[1].target_pc = 32'h8000_0040;
      step(2);
      check("seq_redirect_pc", 64'(redirect_pc), 64'h8000_0040);
      set_entries(4'hF, 4'hF, 4'h0);
      step(0);
      set_entries(4'hF, 4'hF, 4'h0);
      step(0);
      set_entries(4'hF, 4'hF, 4'h0);
      step(4);

      // Asynchronous reset in the middle of RECOVER right after a flush.
      set_entries(4'hF, 4'hF, 4'h1);
      he[0].target_pc = 32'h1234_5678;
      step(1);
      set_entries(4'hF, 4'hF, 4'h0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_flush", 64'(flush), 64'd0);
      check("arst_redirect_pc", 64'(redirect_pc), 64'd0);
      check("arst_ret_valid", 64'(ret_valid), 64'd0);
      check("arst_ret_pd", 64'(ret_pd), 64'd0);
      check("arst_free_pd", 64'(free_pd), 64'd0);
      check("arst_pop", 64'(pop), 64'd0);
      check("arst_amount", 64'(amount), 64'd0);
      set_entries(4'h0, 4'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      rec_left  = 0;
      exp_count = 0;
      @(posedge clk);
      #1;

      // First retires after reset happen in RUN: 3 then 4.
      set_entries(4'h7, 4'hF, 4'h0);
      step(3);
`ifdef COMMIT_TRACE_EN
      check("trace_count_3", commit_count, 64'd3);
`endif
      set_entries(4'hF, 4'hF, 4'h0);
      step(4);
`ifdef COMMIT_TRACE_EN
      check("trace_count_7", commit_count, 64'd7);
      check("trace_order0_3", ret_order[0], 64'd3);
`endif

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         logic [3:0] v, d, m;
         for (int i = 0; i < SUPERSCALAR; i++) begin
            v[i] = ($urandom_range(0, 7) != 0);
            d[i] = ($urandom_range(0, 5) != 0);
            m[i] = ($urandom_range(0, 11) == 0);
         end
         set_entries(v, d, m);
         stall = ($urandom_range(0, 7) == 0);
         step(model_k());
      end
      stall = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
